// File: rtl/v2f_ram.sv
// v2f_ram: DEPTH x WIDTH signed word store with a fixed-latency read pipeline
// and a sequential bulk-clear engine (one word zeroed per cycle).
// Build option: define V2F_RAM_WR_FORWARD_EN for write-first behaviour on a
// same-cycle, same-address read/write; otherwise the read is read-first.
module v2f_ram #(
  parameter int DEPTH      = 16,
  parameter int ABITS      = 4,
  parameter int WIDTH      = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    WR_EN,
  input  logic [ABITS-1:0]        WR_ADDR,
  input  logic signed [WIDTH-1:0] WR_DATA,
  input  logic                    RD_EN,
  input  logic [ABITS-1:0]        RD_ADDR,
  output logic signed [WIDTH-1:0] RD_DATA,
  output logic                    RD_VALID,
  input  logic                    CLR,
  output logic                    BUSY
);

  // Counter is one bit wider than the address so it cannot wrap at DEPTH=2^ABITS.
  localparam logic [ABITS:0] DEPTH_W = (ABITS+1)'(DEPTH);
  localparam logic [ABITS:0] LAST_W  = (ABITS+1)'(DEPTH - 1);

  typedef enum logic {IDLE, CLEARING} state_t;

  state_t                  state_q, state_d;
  logic [ABITS:0]          cnt_q, cnt_d;
  logic                    busy;
  logic                    wr_acc, rd_acc, clr_we;
  logic                    mem_we;
  logic [ABITS-1:0]        mem_wa;
  logic signed [WIDTH-1:0] mem_wd;
  logic signed [WIDTH-1:0] rd_word;

  logic signed [WIDTH-1:0] mem [DEPTH];

  logic [RD_LATENCY-1:0]   rd_vld_p;
  logic signed [WIDTH-1:0] rd_data_p [RD_LATENCY];

  function automatic logic in_range(input logic [ABITS-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  // Clear FSM state and counter register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: CLR starts a sweep from word 0; the sweep ends on the last word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (CLR) begin
          state_d = CLEARING;
          cnt_d   = '0;
        end
      end
      CLEARING: begin
        if (cnt_q == LAST_W) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: BUSY mirrors the CLEARING state.
  always_comb begin
    busy = (state_q == CLEARING);
    BUSY = busy;
  end

  // Port acceptance; a reset edge suppresses every array write, including a clear step.
  always_comb begin
    wr_acc = WR_EN && !busy && !RST && in_range(WR_ADDR);
    rd_acc = RD_EN && !busy;
    clr_we = busy && !RST;
  end

  // Single physical write port shared between the user and the clear engine.
  always_comb begin
    mem_we = wr_acc || clr_we;
    mem_wa = clr_we ? cnt_q[ABITS-1:0] : WR_ADDR;
    mem_wd = clr_we ? '0 : WR_DATA;
  end

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Read sample: out-of-range returns 0; optional write-first forwarding on collision.
  always_comb begin
    rd_word = '0;
    if (in_range(RD_ADDR)) begin
      rd_word = mem[RD_ADDR];
`ifdef V2F_RAM_WR_FORWARD_EN
      if (wr_acc && (WR_ADDR == RD_ADDR)) rd_word = WR_DATA;
`else
      rd_word = mem[RD_ADDR];
`endif
    end
  end

  // Stage p0 .. p(RD_LATENCY-1): valid shift chain, flushed by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_vld_p <= '0;
    end else begin
      rd_vld_p[0] <= rd_acc;
      for (int i = 1; i < RD_LATENCY; i++) rd_vld_p[i] <= rd_vld_p[i-1];
    end
  end

  // Stage p0 .. p(RD_LATENCY-1): data shift chain travelling beside the valids.
  always_ff @(posedge CLK) begin
    rd_data_p[0] <= rd_acc ? rd_word : '0;
    for (int i = 1; i < RD_LATENCY; i++) rd_data_p[i] <= rd_data_p[i-1];
  end

  // Output stage: data is forced to 0 ("no signal") whenever valid is low.
  always_comb begin
    RD_VALID = rd_vld_p[RD_LATENCY-1];
    RD_DATA  = RD_VALID ? rd_data_p[RD_LATENCY-1] : '0;
  end

endmodule

// File: tb/tb_v2f_ram.sv
// Scoreboard bench for v2f_ram: stimulus pushes expected read results with
// their due cycle; per-instance monitors pop and compare on RD_VALID.
module tb_v2f_ram;

  localparam int L = 2;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en, clr;
  logic [3:0]  wr_addr, rd_addr;
  logic [31:0] wr_data, rd_data;
  logic        rd_valid, busy;

  logic        b_we, b_re, b_clr;
  logic [3:0]  b_wa, b_ra;
  logic [31:0] b_wd, b_rd;
  logic        b_rv, b_busy;

  exp_t q[$];
  exp_t q12[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_tot = 0;
  bit   mon_en = 1'b0;
  logic [31:0] exp_col;

  v2f_ram #(.DEPTH(16), .ABITS(4), .WIDTH(32), .RD_LATENCY(L)) u_dut (
    .CLK(clk), .RST(rst),
    .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .RD_EN(rd_en), .RD_ADDR(rd_addr), .RD_DATA(rd_data), .RD_VALID(rd_valid),
    .CLR(clr), .BUSY(busy)
  );

  v2f_ram #(.DEPTH(12), .ABITS(4), .WIDTH(32), .RD_LATENCY(L)) u_d12 (
    .CLK(clk), .RST(rst),
    .WR_EN(b_we), .WR_ADDR(b_wa), .WR_DATA(b_wd),
    .RD_EN(b_re), .RD_ADDR(b_ra), .RD_DATA(b_rd), .RD_VALID(b_rv),
    .CLR(b_clr), .BUSY(b_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tot++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_valid) begin
        if (q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
        else begin : pop_main
          exp_t e;
          e = q.pop_front();
          chk("rd_data", rd_data, e.data);
          chk("rd_latency", cyc, e.cyc);
        end
      end else begin
        chk("idle_zero", rd_data, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (b_rv) begin
        if (q12.size() == 0) chk("d12_unexpected_valid", 32'd1, 32'd0);
        else begin : pop_d12
          exp_t e;
          e = q12.pop_front();
          chk("d12_rd_data", b_rd, e.data);
          chk("d12_rd_latency", cyc, e.cyc);
        end
      end else begin
        chk("d12_idle_zero", b_rd, 32'd0);
      end
    end
  end

  task automatic push(input logic [31:0] d);
    exp_t e;
    e.data = d;
    e.cyc  = cyc + L;
    q.push_back(e);
  endtask

  task automatic push12(input logic [31:0] d);
    exp_t e;
    e.data = d;
    e.cyc  = cyc + L;
    q12.push_back(e);
  endtask

  task automatic step(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                      input logic re, input logic [3:0] ra, input logic c);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra; clr = c;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    step(1'b1, a, d, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    push(e);
    step(1'b0, 4'd0, 32'd0, 1'b1, a, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    b_we = 1'b0; b_re = 1'b0; b_clr = 1'b0;
    b_wa = '0; b_ra = '0; b_wd = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    mon_en = 1'b1;

    // Write then read with fixed latency; zero data either side of the pulse.
    wr(4'd5, 32'h0000_1234);
    rd(4'd5, 32'h0000_1234);
    repeat (4) idle();

    // Negative values, back-to-back reads.
    wr(4'd0, 32'hFFFF_FFFF);
    wr(4'd1, 32'h8000_0000);
    wr(4'd2, 32'h0000_0007);
    rd(4'd0, 32'hFFFF_FFFF);
    rd(4'd1, 32'h8000_0000);
    rd(4'd2, 32'h0000_0007);
    repeat (4) idle();

    // A read in flight when reset arrives must never surface.
    step(1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 1'b0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    repeat (3) idle();

    // Same-cycle write/read collision.
`ifdef V2F_RAM_WR_FORWARD_EN
    exp_col = 32'h55;
`else
    exp_col = 32'h11;
`endif
    wr(4'd3, 32'h11);
    push(exp_col);
    step(1'b1, 4'd3, 32'h55, 1'b1, 4'd3, 1'b0);
    rd(4'd3, 32'h55);
    repeat (4) idle();

    // Bulk clear: CLR with a same-cycle write and read, then 16 busy cycles.
    for (int i = 0; i < 16; i++) wr(4'(i), 32'h100 + 32'(i));
    push(32'h104);
    step(1'b1, 4'd6, 32'h4444, 1'b1, 4'd4, 1'b1);
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == 3) step(1'b1, 4'd5, 32'h777, 1'b1, 4'd5, 1'b0);
      else idle();
    end
    chk("busy_cycles", 32'(n), 32'd16);
    for (int i = 0; i < 16; i++) rd(4'(i), 32'd0);
    repeat (4) idle();

    // Reset after six clear writes: words 0..5 zero, the rest intact.
    for (int i = 0; i < 16; i++) wr(4'(i), 32'hAA);
    step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b1);
    repeat (6) idle();
    chk("busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    chk("busy_after_rst", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 16; i++) rd(4'(i), (i < 6) ? 32'd0 : 32'hAA);
    repeat (4) idle();

    // Out-of-range on a DEPTH=12 instance.
    b_we = 1'b1; b_wa = 4'd11; b_wd = 32'h0000_000B;
    @(negedge clk);
    b_wa = 4'd13; b_wd = 32'd99;
    @(negedge clk);
    b_we = 1'b0;
    push12(32'd0);
    b_re = 1'b1; b_ra = 4'd13;
    @(negedge clk);
    push12(32'd0);
    b_ra = 4'd12;
    @(negedge clk);
    push12(32'h0000_000B);
    b_ra = 4'd11;
    @(negedge clk);
    b_re = 1'b0;
    repeat (5) idle();

    chk("queues_drained", 32'(q.size() + q12.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/v2f_ram.md
Name: v2f_ram

Overview:
- Sequential storage cell produced downstream of the v2f arithmetic/compare/mux cells when memories are techmapped to the Factorio back end.
- Holds DEPTH signed words of WIDTH bits and gives one write port and one read port.
- Read latency is fixed and counts combinator ticks, so simulation matches blueprint timing.
- Has a sequential bulk-clear engine, because a Factorio memory cannot be zeroed in one tick.

Parameters:
DEPTH, 16, number of words; 2..256
ABITS, 4, address width; 2^ABITS >= DEPTH
WIDTH, 32, word width; 1..32, stored as two's complement int32 signal
RD_LATENCY, 2, cycles from accepted read to RD_VALID; 1..4

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous active-high reset
WR_EN  in  1  write request
WR_ADDR  in  ABITS  write address
WR_DATA  in  WIDTH  write data
RD_EN  in  1  read request
RD_ADDR  in  ABITS  read address
RD_DATA  out  WIDTH  read data, valid when RD_VALID=1
RD_VALID  out  1  one-cycle pulse per accepted read
CLR  in  1  bulk-clear request, sampled on rising edge
BUSY  out  1  high while clear engine runs

Behaviour:
- Clock and reset: one clock CLK; reset RST is synchronous and active-high.
- Reset values:
  - RD_DATA=0, RD_VALID=0, BUSY=0.
  - Read pipeline flushed; clear counter=0; FSM=IDLE.
  - Array contents are not reset.
- FSM states: IDLE, CLEARING.
  - IDLE -> CLEARING when CLR=1 at an edge. Counter starts at 0.
  - In CLEARING, each cycle writes 0 to word[counter] and increments the counter.
  - At the edge that writes word DEPTH-1, the FSM returns to IDLE. The clear takes exactly DEPTH cycles.
  - BUSY=1 from the cycle after CLR is sampled through the cycle holding the last clear write.
  - CLR during CLEARING is ignored; no restart.
- BUSY gating:
  - While BUSY=1, WR_EN and RD_EN are ignored: no write and no pipeline entry.
  - Reads already in the pipeline still complete and return post-clear-progress data as captured.
  - CLR and WR_EN/RD_EN high in the same IDLE cycle: that write and read are accepted, then clearing starts.
- Write: when WR_EN=1 and not BUSY, word[WR_ADDR] <= WR_DATA at the edge.
- Read:
  - When RD_EN=1 and not BUSY, the array is sampled at that edge.
  - RD_VALID=1 and RD_DATA=value exactly RD_LATENCY edges later.
  - Back-to-back reads are accepted every cycle; throughput is 1 per cycle and no read is dropped.
- RD_DATA is 0 whenever RD_VALID=0, matching Factorio "no signal".
- Out-of-range address (>= DEPTH):
  - Write is dropped.
  - Read is accepted and returns 0 with RD_VALID=1.
- Same-cycle write and read to the same address: see Optional Feature.
- Reset mid-clear:
  - FSM aborts to IDLE and BUSY=0 next cycle.
  - Words already cleared stay 0; the rest keep their old values.
  - The pipeline is flushed, so no RD_VALID is produced for reads in flight.
- Width rules:
  - Data is stored verbatim; no sign extension inside.
  - Counter width is ABITS+1, so it does not wrap when DEPTH=2^ABITS.

Optional Feature:
- Macro: V2F_RAM_WR_FORWARD_EN.
- Defined: a read and write to the same in-range address in the same accepted cycle returns WR_DATA (write-first).
- Undefined: that read returns the previous stored word (read-first), matching the plain combinator memory cell.
- Either way the write commits identically.

Test Plan:
- Write/read latency: RST, write 5 -> 0x0000_1234 (1 cycle), then RD_EN addr 5 at cycle t -> RD_VALID=1 and RD_DATA=0x1234 at t+RD_LATENCY (t+2 default); RD_DATA=0 at t+1 and t+3.
- Negative values and throughput: write addr0=-1, addr1=-2147483648, addr2=7; read 0,1,2 on consecutive cycles -> three consecutive RD_VALID pulses with 0xFFFFFFFF, 0x80000000, 0x00000007.
- Out-of-range (DEPTH=12, ABITS=4): write addr 13 = 99 -> dropped; read addr 13 -> RD_VALID=1, RD_DATA=0; word 12 unchanged.
- Bulk clear:
  - Fill all 16 words with nonzero values, pulse CLR -> BUSY high for exactly 16 cycles.
  - WR_EN during BUSY has no effect.
  - Afterward every read returns 0.
- Reset mid-clear: fill all words with 0xAA, CLR, assert RST after 6 BUSY cycles -> BUSY=0 next cycle; words 0..5 read 0, words 6..15 read 0xAA; no stray RD_VALID.
- Collision: same-cycle write addr3=0x55 and read addr3 (old 0x11) -> RD_DATA=0x55 with V2F_RAM_WR_FORWARD_EN, 0x11 without; a later read returns 0x55 in both builds.
